jk_mod_counter: RTL and testbench

- Synchronous modulo-N up/down counter whose state bits are held in JK flip-flop cells.
- Per-bit J/K excitation logic sits directly upstream of each cell, computed from the desired next state.
- Used as the sequencing/divide stage that feeds downstream lab blocks (clock dividers, display drivers).

---
 rtl/jk_cnt_pkg.sv | 17 +
 rtl/jk_ff_cell.sv | 28 ++
 rtl/jk_mod_counter.sv | 81 ++++++++
 tb/tb_jk_mod_counter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/jk_cnt_pkg.sv
// rtl/jk_cnt_pkg.sv - shared types and helpers for the JK modulo counter
package jk_cnt_pkg;

  // Excitation code as {J, K}.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_code_e;

  // Terminal (highest legal) state for a given modulus.
  function automatic int unsigned mod_last(input int unsigned modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// rtl/jk_ff_cell.sv - single JK flip-flop with asynchronous active-low clear
module jk_ff_cell
  import jk_cnt_pkg::*;
(
  input  logic Clock,
  input  logic ClearN,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic QN
);

  always_ff @(posedge Clock or negedge ClearN) begin
    if (!ClearN) begin
      Q <= 1'b0;
    end else begin
      case (jk_code_e'({J, K}))
        JK_HOLD:   Q <= Q;
        JK_RESET:  Q <= 1'b0;
        JK_SET:    Q <= 1'b1;
        JK_TOGGLE: Q <= ~Q;
      endcase
    end
  end

  assign QN = ~Q;

endmodule

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - modulo-MOD up/down counter built from JK flip-flop cells
// Defining JKCNT_GRAY_OUT_EN adds a registered GrayCount output.
module jk_mod_counter
  import jk_cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             Clock,
  input  logic             ClearN,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Count,
  output logic             TC,
`ifdef JKCNT_GRAY_OUT_EN
  output logic [WIDTH-1:0] GrayCount,
`endif
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(mod_last(MOD));

  logic [WIDTH-1:0] q_vec;
  logic [WIDTH-1:0] qn_vec;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;

  // D <= LAST rather than D < MOD so MOD == 2**WIDTH compares within WIDTH bits.
  always_comb begin
    nxt = q_vec;
    if (Load) begin
      nxt = (D <= LAST) ? D : '0;
    end else if (En) begin
      if (Up) begin
        nxt = (q_vec >= LAST) ? '0 : q_vec + WIDTH'(1);
      end else begin
        nxt = (q_vec == '0) ? LAST : q_vec - WIDTH'(1);
      end
    end
  end

  // Only bits that change get excited, so J and K are never both high.
  assign j_vec = qn_vec & nxt;
  assign k_vec = q_vec & ~nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_cell
    jk_ff_cell u_cell (
      .Clock  (Clock),
      .ClearN (ClearN),
      .J      (j_vec[i]),
      .K      (k_vec[i]),
      .Q      (q_vec[i]),
      .QN     (qn_vec[i])
    );
  end

  assign Count = q_vec;
  assign TC    = En & ~Load & ((Up & (q_vec == LAST)) | (~Up & (q_vec == '0)));

  always_ff @(posedge Clock or negedge ClearN) begin
    if (!ClearN) begin
      Wrap <= 1'b0;
    end else begin
      Wrap <= TC;
    end
  end

`ifdef JKCNT_GRAY_OUT_EN
  always_ff @(posedge Clock or negedge ClearN) begin
    if (!ClearN) begin
      GrayCount <= '0;
    end else begin
      GrayCount <= nxt ^ (nxt >> 1);
    end
  end
`endif

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - self-checking bench for jk_mod_counter (WIDTH=4, MOD=10)
module tb_jk_mod_counter;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  logic             Clock = 1'b0;
  logic             ClearN;
  logic             En;
  logic             Up;
  logic             Load;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Count;
  logic             TC;
  logic             Wrap;
`ifdef JKCNT_GRAY_OUT_EN
  logic [WIDTH-1:0] GrayCount;
`endif

  jk_mod_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
    .Clock     (Clock),
    .ClearN    (ClearN),
    .En        (En),
    .Up        (Up),
    .Load      (Load),
    .D         (D),
    .Count     (Count),
    .TC        (TC),
`ifdef JKCNT_GRAY_OUT_EN
    .GrayCount (GrayCount),
`endif
    .Wrap      (Wrap)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;
  int m_count  = 0;
  int m_wrap   = 0;

  typedef struct {
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] d;
    logic       tc;
    logic [3:0] cnt;
    logic       wrap;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int model_next(int c, bit ld, bit en, bit up, int d);
    if (ld)  return (d < MOD) ? d : 0;
    if (!en) return c;
    if (up)  return (c + 1) % MOD;
    return (c + MOD - 1) % MOD;
  endfunction

  function automatic int model_tc(int c, bit ld, bit en, bit up);
    return (en && !ld && ((up && c == MOD - 1) || (!up && c == 0))) ? 1 : 0;
  endfunction

  task automatic drive(input bit ld, input bit en, input bit up, input int d);
    Load = ld;
    En   = en;
    Up   = up;
    D    = 4'(d);
  endtask

  // One edge against the reference model; entered and left at posedge+1.
  task automatic run_cycle(input bit ld, input bit en, input bit up, input int d,
                           input string tag);
    int exp_tc;
    drive(ld, en, up, d);
    #1;
    exp_tc = model_tc(m_count, ld, en, up);
    check({tag, "_tc"}, int'(TC), exp_tc);
    check({tag, "_jk_excl"}, int'(dut.j_vec & dut.k_vec), 0);
    m_count = model_next(m_count, ld, en, up, d);
    m_wrap  = exp_tc;
    @(posedge Clock);
    #1;
    check({tag, "_count"}, int'(Count), m_count);
    check({tag, "_wrap"}, int'(Wrap), m_wrap);
`ifdef JKCNT_GRAY_OUT_EN
    check({tag, "_gray"}, int'(GrayCount), m_count ^ (m_count >> 1));
`endif
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 4'd6,  1'b0, 4'd6, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 4'd12, 1'b0, 4'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 4'd9, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd8, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 4'd9,  1'b0, 4'd9, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 4'd9,  1'b0, 4'd9, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 4'd0,  1'b1, 4'd0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'd0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 4'd1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 4'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 4'd5,  1'b0, 4'd5, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd5, 1'b0};

    ClearN = 1'b0;
    drive(0, 0, 0, 0);
    #1;
    check("reset_count", int'(Count), 0);
    check("reset_wrap", int'(Wrap), 0);
    check("reset_tc", int'(TC), 0);
    @(posedge Clock);
    #1;
    ClearN = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].load, tbl[i].en, tbl[i].up, int'(tbl[i].d));
      #1;
      check($sformatf("tbl%0d_tc", i), int'(TC), int'(tbl[i].tc));
      @(posedge Clock);
      #1;
      check($sformatf("tbl%0d_count", i), int'(Count), int'(tbl[i].cnt));
      check($sformatf("tbl%0d_wrap", i), int'(Wrap), int'(tbl[i].wrap));
    end
    m_count = 5;
    m_wrap  = 0;

    // Hold at 5: every cell must see J=K=0.
    for (int i = 0; i < 4; i++) begin
      run_cycle(0, 0, 1, 0, "hold");
      check("hold_j", int'(dut.j_vec), 0);
      check("hold_k", int'(dut.k_vec), 0);
      check("hold_count5", int'(Count), 5);
    end

    run_cycle(1, 0, 0, 0, "load0");
    for (int i = 0; i < 10; i++) begin
      run_cycle(0, 1, 1, 0, "up_sweep");
      check("up_sweep_const", int'(Count), (i == 9) ? 0 : i + 1);
      check("up_sweep_wrap_const", int'(Wrap), (i == 9) ? 1 : 0);
    end

    // Clear mid-cycle right after a wrap: Wrap must drop without an edge.
    #2;
    ClearN = 1'b0;
    #1;
    check("async_clr_wrap", int'(Wrap), 0);
    check("async_clr_count0", int'(Count), 0);
    @(posedge Clock);
    #1;
    ClearN = 1'b1;
    m_count = 0;
    m_wrap  = 0;

    run_cycle(0, 1, 0, 0, "down_from0");
    check("down_from0_const", int'(Count), 9);
    run_cycle(0, 1, 0, 0, "down_to8");
    check("down_to8_const", int'(Count), 8);

    run_cycle(1, 0, 0, 7, "load7");
    #2;
    drive(0, 1, 1, 0);
    ClearN = 1'b0;
    #1;
    check("mid_clr_count", int'(Count), 0);
    check("mid_clr_wrap", int'(Wrap), 0);
    repeat (2) @(posedge Clock);
    #1;
    check("clr_held_count", int'(Count), 0);
    check("clr_held_wrap", int'(Wrap), 0);
    ClearN = 1'b1;
    m_count = 0;
    m_wrap  = 0;
    run_cycle(0, 1, 1, 0, "post_clr");
    check("post_clr_const", int'(Count), 1);

    for (int i = 0; i < 400; i++) begin
      run_cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
